ps2_scancode_rx: RTL

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_scancode_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver. Synchronises and de-glitches the PS/2 clock,
//   samples data on each filtered falling edge, checks odd parity and the
//   stop bit, folds E0/F0 prefix bytes into flags and presents completed
//   scancodes.
//
// Parameters
//   FILTER_LEN     consecutive equal samples needed to accept a new clock level
//   TIMEOUT_CYCLES max clk_sys cycles between falling edges inside a frame
//
// Build option
//   PS2_RX_TIMEOUT_EN  when defined, a stalled frame is abandoned after
//                      TIMEOUT_CYCLES and reported through frame_err.
//
// Ports
//   clk_sys      in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   ps2_kbd_clk  in   asynchronous PS/2 clock
//   ps2_kbd_data in   asynchronous PS/2 data
//   key_code     out  last completed non-prefix scancode
//   key_ext      out  E0 prefix preceded key_code
//   key_release  out  F0 prefix preceded key_code
//   key_strobe   out  one-cycle pulse when key_* update
//   frame_err    out  one-cycle pulse on a rejected frame
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Synchronisers: bit 0 = PS/2 clock, bit 1 = PS/2 data
  logic [1:0] sync_meta_reg;
  logic [1:0] sync_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_meta_reg <= 2'b11;
      sync_reg      <= 2'b11;
    end else begin
      sync_meta_reg <= {ps2_kbd_data, ps2_kbd_clk};
      sync_reg      <= sync_meta_reg;
    end
  end

  logic clk_s;
  logic data_s;
  assign clk_s  = sync_reg[0];
  assign data_s = sync_reg[1];

  // Clock filter: a level change is accepted on the FILTER_LEN-th
  // consecutive sample that disagrees with the current filtered level.
  logic           filt_clk_reg, filt_clk_next;
  logic [FCW-1:0] filt_cnt_reg, filt_cnt_next;

  always_comb begin
    filt_clk_next = filt_clk_reg;
    filt_cnt_next = '0;
    if (clk_s != filt_clk_reg) begin
      if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
        filt_clk_next = clk_s;
      end else begin
        filt_cnt_next = filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      filt_clk_reg <= filt_clk_next;
      filt_cnt_reg <= filt_cnt_next;
    end
  end

  // Sample event is the cycle on which the filtered clock falls; data is
  // captured on the same clock edge that commits the new filtered level.
  logic sample_evt;
  assign sample_evt = filt_clk_reg & ~filt_clk_next;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       parity_reg;
  logic       ext_pending_reg;
  logic       rel_pending_reg;
  logic [7:0] key_code_reg;
  logic       key_ext_reg;
  logic       key_release_reg;
  logic       key_strobe_reg;
  logic       frame_err_reg;

  // Timeout: a sample event always wins over an expiry on the same cycle.
  logic timeout_fire;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_cnt_reg;

  always_ff @(posedge clk_sys) begin
    if (reset || state_reg == ST_IDLE || sample_evt) begin
      timeout_cnt_reg <= '0;
    end else if (timeout_cnt_reg != TW'(TIMEOUT_CYCLES)) begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end

  assign timeout_fire = (timeout_cnt_reg == TW'(TIMEOUT_CYCLES)) && !sample_evt;
`else
  assign timeout_fire = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    if (timeout_fire) begin
      state_next = ST_IDLE;
    end else if (sample_evt) begin
      case (state_reg)
        ST_IDLE:   if (!data_s) state_next = ST_DATA;
        ST_DATA:   if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdict and prefix decode
  logic frame_done, frame_ok, frame_bad;
  logic load_key, set_ext, set_rel, clear_pending, err_pulse;

  always_comb begin
    frame_done    = sample_evt && (state_reg == ST_STOP);
    // Odd parity over data+parity means the XOR of all nine bits is 1.
    frame_ok      = frame_done && (^{shift_reg, parity_reg}) && data_s;
    frame_bad     = frame_done && !frame_ok;
    set_ext       = frame_ok && (shift_reg == 8'hE0);
    set_rel       = frame_ok && (shift_reg == 8'hF0);
    load_key      = frame_ok && !set_ext && !set_rel;
    clear_pending = load_key || frame_bad || timeout_fire;
    err_pulse     = frame_bad || timeout_fire;
  end

  // Datapath
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_reg      <= 1'b0;
      ext_pending_reg <= 1'b0;
      rel_pending_reg <= 1'b0;
      key_code_reg    <= '0;
      key_ext_reg     <= 1'b0;
      key_release_reg <= 1'b0;
      key_strobe_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      key_strobe_reg <= load_key;
      frame_err_reg  <= err_pulse;

      if (timeout_fire) begin
        bit_cnt_reg <= '0;
      end else if (sample_evt) begin
        case (state_reg)
          ST_IDLE:   bit_cnt_reg <= '0;
          ST_DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
          ST_PARITY: parity_reg <= data_s;
          default:   ;
        endcase
      end

      if (load_key) begin
        key_code_reg    <= shift_reg;
        key_ext_reg     <= ext_pending_reg;
        key_release_reg <= rel_pending_reg;
      end

      if (clear_pending) begin
        ext_pending_reg <= 1'b0;
        rel_pending_reg <= 1'b0;
      end else begin
        if (set_ext) ext_pending_reg <= 1'b1;
        if (set_rel) rel_pending_reg <= 1'b1;
      end
    end
  end

  assign key_code    = key_code_reg;
  assign key_ext     = key_ext_reg;
  assign key_release = key_release_reg;
  assign key_strobe  = key_strobe_reg;
  assign frame_err   = frame_err_reg;

endmodule
